// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the instruction/data memory arbiter: widths, RV32I
// load/store funct3 codes and the grant-owner state encoding.
package mem_arbiter_pkg;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int FUNCT3_W = 3;

  localparam logic [FUNCT3_W-1:0] F3_LB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_LH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_LW  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_LBU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_LHU = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_SB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_SH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_align_check.sv
// Combinational legality check for a data access: funct3 validity per
// direction plus natural alignment of half and word accesses.
module mem_align_check
  import mem_arbiter_pkg::*;
(
  input  logic                we,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [1:0]          addr_lo,
  output logic                illegal
);

  always_comb begin
    illegal = 1'b0;
    if (we) begin
      case (funct3)
        F3_SB:   illegal = 1'b0;
        F3_SH:   illegal = addr_lo[0];
        F3_SW:   illegal = |addr_lo;
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: illegal = 1'b0;
        F3_LH, F3_LHU: illegal = addr_lo[0];
        F3_LW:         illegal = |addr_lo;
        default:       illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and data access;
// data wins contention until it has starved fetch for STARVE_LIM grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [FUNCT3_W-1:0] d_funct3,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [FUNCT3_W-1:0] funct3,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W-1:0]   data_out
);

  localparam int STREAK_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [STREAK_W-1:0] LIM = STREAK_W'(STARVE_LIM);

  arb_state_t          state, state_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;
  logic                d_illegal;

  mem_align_check u_align (
    .we      (d_we),
    .funct3  (d_funct3),
    .addr_lo (d_addr[1:0]),
    .illegal (d_illegal)
  );

  // Grant decision is gated by rst_n so nothing reaches memory during reset
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_n) begin
      if (if_req && d_req) begin
        if (streak == LIM) if_gnt = 1'b1;
        else               d_gnt  = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    if (if_gnt)     state_nxt = ST_FETCH;
    else if (d_gnt) state_nxt = ST_DATA;

    streak_nxt = streak;
    if (!if_req || if_gnt)          streak_nxt = '0;
    else if (d_gnt && streak != LIM) streak_nxt = streak + STREAK_W'(1);
  end

  // Illegal data accesses still present addr/funct3 but never strobe memory
  always_comb begin
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    funct3   = '0;
    addr     = '0;
    data_in  = '0;
    if (if_gnt) begin
      funct3 = F3_LW;
      addr   = if_addr;
    end else if (d_gnt) begin
      funct3 = d_funct3;
      addr   = d_addr;
      if (!d_illegal) begin
        MemRead  = !d_we;
        MemWrite = d_we;
        if (d_we) data_in = d_wdata;
      end
    end
  end

  assign if_rvalid = (state == ST_FETCH);
  assign d_rvalid  = (state == ST_DATA);

  // Response stage: capture memory read data at the grant edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      streak   <= '0;
      d_err    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      d_err  <= d_gnt && d_illegal;
      if (if_gnt) if_rdata <= data_out;
      if (d_gnt)  d_rdata  <= (d_illegal || d_we) ? '0 : data_out;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 2: max consecutive data grants while a fetch waits.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_req  input  1  fetch request, held until if_gnt.
REQ-005 SHALL have port if_addr  input  8  fetch byte address.
REQ-006 SHALL have port if_gnt  output  1  fetch granted this cycle (combinational).
REQ-007 SHALL have port if_rvalid  output  1  fetch word valid, one-cycle pulse.
REQ-008 SHALL have port if_rdata  output  32  fetched instruction (registered).
REQ-009 SHALL have port d_req  input  1  data request, held until d_gnt.
REQ-010 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port d_funct3  input  3  access size/sign, RV32I load/store encoding.
REQ-012 SHALL have port d_addr  input  8  data byte address.
REQ-013 SHALL have port d_wdata  input  32  store data.
REQ-014 SHALL have port d_gnt  output  1  data granted this cycle (combinational).
REQ-015 SHALL have port d_rvalid  output  1  data access complete, one-cycle pulse (loads and stores).
REQ-016 SHALL have port d_rdata  output  32  load result (registered).
REQ-017 SHALL have port d_err  output  1  misaligned/illegal access, valid with d_rvalid.
REQ-018 SHALL have ports MemRead, MemWrite (output 1), funct3 (output 3), addr (output 8), data_in (output 32), data_out (input 32): single-port memory interface.

Function
REQ-019 SHALL grant at most one port per cycle; fetch-only grants fetch, data-only grants data, neither grants nothing.
REQ-020 SHALL grant data on simultaneous requests unless the data streak counter equals STARVE_LIM, then fetch.
REQ-021 SHALL increment the streak counter (saturating at STARVE_LIM) on each data grant while if_req is high; clear it on any fetch grant or when if_req is low.
REQ-022 SHALL hold state IDLE/DATA/FETCH = owner of previous cycle's grant; IDLE when none.
REQ-023 SHALL on fetch grant drive MemRead=0, MemWrite=0, addr=if_addr (memory word path).
REQ-024 SHALL on legal data load drive MemRead=1, MemWrite=0, funct3=d_funct3, addr=d_addr.
REQ-025 SHALL on legal data store drive MemRead=0, MemWrite=1, funct3=d_funct3, addr=d_addr, data_in=d_wdata; memory commits at same edge.
REQ-026 SHALL with no grant drive MemRead=0, MemWrite=0, addr=0, data_in=0, funct3=0.
REQ-027 SHALL capture data_out at the grant edge; rvalid and rdata appear exactly 1 cycle after grant.
REQ-028 SHALL flag illegal: word access with addr[1:0]!=0; half access with addr[0]!=0; load funct3 not in {000,001,010,100,101}; store funct3 not in {000,001,010}.
REQ-029 SHALL on illegal access still grant, suppress MemRead/MemWrite, then pulse d_rvalid with d_err=1, d_rdata=0.
REQ-030 SHALL keep if_rdata/d_rdata stable between rvalid pulses.
REQ-031 SHALL permit back-to-back grants every cycle with no bubble.

Reset
REQ-032 SHALL on rst_n low asynchronously set state=IDLE, streak=0, if_rvalid=0, d_rvalid=0, d_err=0, if_rdata=0, d_rdata=0.
REQ-033 SHALL drop any access whose response cycle falls during reset; no rvalid after reset release for it.
REQ-034 SHALL grant nothing while rst_n is low.

Structure
REQ-035 SHALL take funct3 codes, state encodings and width constants from the shared defines file.
REQ-036 SHALL place legality check in one combinational sub-module, mem_align_check.

Verification
REQ-037 Fetch-only: if_req, if_addr=4 -> if_gnt same cycle, next cycle if_rvalid=1, if_rdata=word at 4.
REQ-038 Contention: if_req and d_req held, STARVE_LIM=2 -> grants D,D,F,D,D,F; no fetch waits >2 cycles.
REQ-039 Store/load: SW 0x12345678 @80, then LB @83 -> d_rdata=0x00000012; LH @82 -> 0x00001234.
REQ-040 Misaligned: LW @66 -> MemRead=0, next cycle d_rvalid=1, d_err=1, d_rdata=0; memory unchanged.
REQ-041 Reset mid-op: rst_n low after data grant, before response -> d_rvalid stays 0, outputs 0, state IDLE.
REQ-042 Illegal store funct3=100 @64 -> MemWrite=0, d_err=1, word at 64 still 17.
